// File: rtl/serial_byte_assembler_pkg.sv
// Shared types and helpers for the serial-to-parallel word assembler.
// The bit placement helper works on a fixed 32-bit container so any WIDTH up to 32 can use it.
package serial_byte_assembler_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam int MAX_W     = 32;
  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Shift one bit into the low WIDTH bits of cur; bits above WIDTH stay zero.
  function automatic logic [MAX_W-1:0] place_bit(input logic [MAX_W-1:0] cur,
                                                 input logic             b,
                                                 input int               width,
                                                 input bit               lsb_first);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] ext;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    ext  = MAX_W'(b);
    if (lsb_first) begin
      return ((cur >> 1) | (ext << (width - 1))) & mask;
    end
    return ((cur << 1) | ext) & mask;
  endfunction

endpackage

// File: rtl/serial_byte_assembler_shift.sv
// Assembly register: shifts accepted bits in, counts them and flags a full word.
// drain returns the count to zero after the word has been copied out.
module serial_shift_reg
  import serial_byte_assembler_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit INVERT    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         shift_en,
  input  logic                         drain,
  input  logic                         bit_in,
  output logic [WIDTH-1:0]             data,
  output logic [WIDTH-1:0]             shifted,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         last,
  output logic                         full
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign shifted = WIDTH'(place_bit(MAX_W'(data_q), bit_in ^ INVERT, WIDTH, LSB_FIRST));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      data_d  = '0;
      count_d = '0;
    end else begin
      if (shift_en) begin
        data_d  = shifted;
        count_d = count_q + CNT_W'(1);
      end
      if (drain) begin
        count_d = '0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign count = count_q;
  assign last  = (count_q == CNT_W'(WIDTH - 1));
  assign full  = (count_q == CNT_W'(WIDTH));

endmodule

// File: rtl/serial_byte_assembler.sv
// Serial bit stream in (valid/ready), parallel words out (valid/ready) through a one-entry slot.
// FULL parks a completed word in the assembly register while the output slot is occupied.
module serial_byte_assembler
  import serial_byte_assembler_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit INVERT    = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             accept, slot_free, drain, last, full;
  logic [WIDTH-1:0] asm_data, asm_shifted;

  assign slot_free = !word_valid_q || word_ready;
  assign accept    = bit_valid && bit_ready && !clear;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .INVERT    (INVERT)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (accept),
    .drain    (drain),
    .bit_in   (bit_in),
    .data     (asm_data),
    .shifted  (asm_shifted),
    .count    (bit_count),
    .last     (last),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: if (accept && last && !slot_free) state_d = FULL;
        FULL:    if (slot_free)                    state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // A completing bit and a consumed word on the same edge hand off with no bubble.
  always_comb begin
    bit_ready    = (state_q == COLLECT);
    drain        = 1'b0;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q && !word_ready;
    if (clear) begin
      word_valid_d = 1'b0;
    end else if (state_q == COLLECT && accept && last && slot_free) begin
      word_out_d   = asm_shifted;
      word_valid_d = 1'b1;
      drain        = 1'b1;
    end else if (state_q == FULL && full && slot_free) begin
      word_out_d   = asm_data;
      word_valid_d = 1'b1;
      drain        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Self-checking bench: LSB-first/plain and MSB-first/inverted instances share one stimulus stream,
// a negedge monitor models both and scoreboards every consumed word.
module tb_serial_byte_assembler;

  logic       clk = 1'b0;
  logic       rst_n, clear, bit_in, bit_valid, word_ready;
  logic       bit_ready_a, bit_ready_b, word_valid_a, word_valid_b;
  logic [7:0] word_out_a, word_out_b;
  logic [3:0] bit_count_a, bit_count_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] asm_a, asm_b;
  int         cnt_a, cnt_b;

  always #5 clk = ~clk;

  serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b1), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_a), .word_out(word_out_a), .word_valid(word_valid_a),
    .word_ready(word_ready), .bit_count(bit_count_a)
  );

  serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b0), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_b), .word_out(word_out_b), .word_valid(word_valid_b),
    .word_ready(word_ready), .bit_count(bit_count_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one bit per cycle, seq[0] first.
  task automatic send_word(input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = seq[i];
      step();
    end
    bit_valid = 1'b0;
  endtask

  // Reference model and scoreboard, sampled mid-cycle while inputs are stable.
  initial begin
    asm_a = '0; asm_b = '0; cnt_a = 0; cnt_b = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        asm_a = '0; asm_b = '0; cnt_a = 0; cnt_b = 0;
        exp_a.delete();
        exp_b.delete();
      end else begin
        if (word_valid_a && word_ready) begin
          if (exp_a.size() == 0) check("sb_a_unexpected", 32'(exp_a.size()), 32'd1);
          else                   check("sb_a_word", 32'(word_out_a), 32'(exp_a.pop_front()));
        end
        if (word_valid_b && word_ready) begin
          if (exp_b.size() == 0) check("sb_b_unexpected", 32'(exp_b.size()), 32'd1);
          else                   check("sb_b_word", 32'(word_out_b), 32'(exp_b.pop_front()));
        end
        if (bit_valid && bit_ready_a) begin
          asm_a = {bit_in, asm_a[7:1]};
          cnt_a++;
          if (cnt_a == 8) begin exp_a.push_back(asm_a); cnt_a = 0; end
        end
        if (bit_valid && bit_ready_b) begin
          asm_b = {asm_b[6:0], ~bit_in};
          cnt_b++;
          if (cnt_b == 8) begin exp_b.push_back(asm_b); cnt_b = 0; end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq;
    int         pulses, drops;

    rst_n = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b1;
    #2;
    check("rst_word_valid", 32'(word_valid_a), 32'd0);
    check("rst_bit_ready",  32'(bit_ready_a),  32'd1);
    check("rst_bit_count",  32'(bit_count_a),  32'd0);
    check("rst_word_out",   32'(word_out_a),   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Bit order: 1,0,1,0,0,0,1,1 -> 8'hC5 LSB-first; inverted MSB-first gives 8'h5C.
    seq = 8'b1100_0101;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = seq[i];
      step();
      check("order_bit_count", 32'(bit_count_a), 32'((i + 1) % 8));
      check("order_latency",   32'(word_valid_a), (i == 7) ? 32'd1 : 32'd0);
    end
    bit_valid = 1'b0;
    check("order_word_a", 32'(word_out_a), 32'hC5);
    check("order_word_b", 32'(word_out_b), 32'h5C);
    step();
    check("order_consumed", 32'(word_valid_a), 32'd0);

    // Inversion and MSB-first: 0,0,0,0,1,1,1,1 -> 8'hF0 on both instances.
    send_word(8'b1111_0000);
    check("inv_word_b", 32'(word_out_b), 32'hF0);
    check("inv_word_a", 32'(word_out_a), 32'hF0);
    step();

    // Backpressure: two words with the consumer stalled.
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seq       = (i < 8) ? 8'hA5 : 8'h3C;
      bit_valid = 1'b1;
      bit_in    = seq[i % 8];
      step();
    end
    check("bp_ready_low",  32'(bit_ready_a),  32'd0);
    check("bp_count_full", 32'(bit_count_a),  32'd8);
    check("bp_held_word",  32'(word_out_a),   32'hA5);
    bit_in = 1'b1;
    step();
    step();
    check("bp_ignored_count", 32'(bit_count_a), 32'd8);
    check("bp_stable_word",   32'(word_out_a),  32'hA5);
    check("bp_stable_valid",  32'(word_valid_a), 32'd1);
    bit_valid  = 1'b0;
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("bp_second_word",  32'(word_out_a),   32'h3C);
    check("bp_second_valid", 32'(word_valid_a), 32'd1);
    check("bp_ready_back",   32'(bit_ready_a),  32'd1);
    check("bp_count_zero",   32'(bit_count_a),  32'd0);
    word_ready = 1'b1;
    step();

    // Back-to-back: three words at one bit per cycle with the consumer always ready.
    pulses = 0;
    drops  = 0;
    for (int i = 0; i < 24; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom_range(0, 1));
      if (!bit_ready_a) drops++;
      step();
      if (word_valid_a) pulses++;
    end
    bit_valid = 1'b0;
    check("b2b_ready_drops", 32'(drops),  32'd0);
    check("b2b_pulses",      32'(pulses), 32'd3);
    step();

    // clear mid-word discards the partial word and the bit offered alongside it.
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      step();
    end
    clear  = 1'b1;
    bit_in = 1'b1;
    step();
    clear     = 1'b0;
    bit_valid = 1'b0;
    check("clr_count",  32'(bit_count_a),  32'd0);
    check("clr_ready",  32'(bit_ready_a),  32'd1);
    send_word(8'h96);
    check("clr_clean_word", 32'(word_out_a), 32'h96);
    step();

    // Asynchronous reset while FULL with a held word.
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      bit_in    = i[0];
      step();
    end
    bit_valid = 1'b0;
    check("arst_pre_full",  32'(bit_ready_a),  32'd0);
    check("arst_pre_valid", 32'(word_valid_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_word_valid", 32'(word_valid_a), 32'd0);
    check("arst_bit_ready",  32'(bit_ready_a),  32'd1);
    check("arst_bit_count",  32'(bit_count_a),  32'd0);
    check("arst_word_out",   32'(word_out_a),   32'd0);
    step();
    rst_n      = 1'b1;
    word_ready = 1'b1;

    send_word(8'h5A);
    step();
    step();
    check("sb_a_drained", 32'(exp_a.size()), 32'd0);
    check("sb_b_drained", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
